// File: rtl/axi4_lite_slave_access_scheduler_pkg.sv
// Shared types for the AXI4-Lite slave access scheduler: FSM states, grant
// encoding, response codes and the ready-delay clamp.
package Axi4LiteGlobalsPkg;

  localparam int unsigned MAX_DELAY_VALUE = 15;
  localparam int unsigned DELAY_CNT_WIDTH = $clog2(MAX_DELAY_VALUE + 1);

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StWait   = 2'd1,
    StAccess = 2'd2,
    StResp   = 2'd3
  } sched_state_e;

  typedef enum logic {
    GrantRead  = 1'b0,
    GrantWrite = 1'b1
  } sched_grant_e;

  typedef enum logic [1:0] {
    BrespOkay   = 2'b00,
    BrespExokay = 2'b01,
    BrespSlverr = 2'b10,
    BrespDecerr = 2'b11
  } brespEnum;

  typedef enum logic [1:0] {
    RrespOkay   = 2'b00,
    RrespExokay = 2'b01,
    RrespSlverr = 2'b10,
    RrespDecerr = 2'b11
  } rrespEnum;

  function automatic brespEnum bresp_from_err(input logic err);
    return err ? BrespSlverr : BrespOkay;
  endfunction

  function automatic rrespEnum rresp_from_err(input logic err);
    return err ? RrespSlverr : RrespOkay;
  endfunction

endpackage

// File: rtl/axi4_lite_slave_access_scheduler_counter.sv
// Ready-delay countdown: loads a clamped delay at grant and counts down to zero.
module axi4_lite_ready_delay_counter
  import Axi4LiteGlobalsPkg::*;
#(
  parameter int unsigned DELAY_WIDTH = 5
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   load_i,
  input  logic [DELAY_WIDTH-1:0] delay_i,
  input  logic                   dec_i,
  output logic                   zero_o
);

  logic [DELAY_CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [31:0]                delay_ext;

  always_comb begin
    delay_ext = 32'(delay_i);
    cnt_d     = cnt_q;
    if (load_i) begin
      cnt_d = (delay_ext > MAX_DELAY_VALUE) ? DELAY_CNT_WIDTH'(MAX_DELAY_VALUE)
                                            : DELAY_CNT_WIDTH'(delay_ext);
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/axi4_lite_slave_access_scheduler.sv
// AXI4-Lite slave front end that serialises reads and writes onto one shared
// register port, with a programmable delay before the address/data ready.
module axi4_lite_slave_access_scheduler
  import Axi4LiteGlobalsPkg::*;
#(
  parameter int unsigned ADDRESS_WIDTH = 32,
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned DELAY_WIDTH   = 5
) (
  input  logic                       aclk,
  input  logic                       areset,
  input  logic                       awvalid,
  input  logic [ADDRESS_WIDTH-1:0]   awaddr,
  input  logic [2:0]                 awprot,
  output logic                       awready,
  input  logic                       wvalid,
  input  logic [DATA_WIDTH-1:0]      wdata,
  input  logic [DATA_WIDTH/8-1:0]    wstrb,
  output logic                       wready,
  output logic                       bvalid,
  output logic [1:0]                 bresp,
  input  logic                       bready,
  input  logic                       arvalid,
  input  logic [ADDRESS_WIDTH-1:0]   araddr,
  input  logic [2:0]                 arprot,
  output logic                       arready,
  output logic                       rvalid,
  output logic [DATA_WIDTH-1:0]      rdata,
  output logic [1:0]                 rresp,
  input  logic                       rready,
  input  logic [DELAY_WIDTH-1:0]     delay_for_ready,
  output logic                       mem_req,
  output logic                       mem_we,
  output logic [ADDRESS_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]      mem_wdata,
  output logic [DATA_WIDTH/8-1:0]    mem_wstrb,
  output logic [2:0]                 mem_prot,
  input  logic [DATA_WIDTH-1:0]      mem_rdata,
  input  logic                       mem_err
);

  sched_state_e              state_q;
  sched_grant_e              grant_q, last_grant_q, grant_d;
  logic [ADDRESS_WIDTH-1:0]  addr_q;
  logic [DATA_WIDTH-1:0]     wdata_q;
  logic [DATA_WIDTH/8-1:0]   wstrb_q;
  logic [2:0]                prot_q;
  logic [DATA_WIDTH-1:0]     rdata_q;
  logic                      err_q;

  logic wr_pend, rd_pend, start, cnt_zero, ready_fire, resp_done;
  brespEnum bresp_val;
  rrespEnum rresp_val;

  // A write is only eligible once both address and data are offered.
  assign wr_pend = awvalid && wvalid;
  assign rd_pend = arvalid;
  assign start   = (state_q == StIdle) && (wr_pend || rd_pend);

  always_comb begin
    grant_d = GrantRead;
    if (wr_pend && rd_pend) begin
      grant_d = (last_grant_q == GrantWrite) ? GrantRead : GrantWrite;
    end else if (wr_pend) begin
      grant_d = GrantWrite;
    end
  end

  axi4_lite_ready_delay_counter #(
    .DELAY_WIDTH(DELAY_WIDTH)
  ) u_delay_counter (
    .clk_i  (aclk),
    .rst_i  (areset),
    .load_i (start),
    .delay_i(delay_for_ready),
    .dec_i  (state_q == StWait),
    .zero_o (cnt_zero)
  );

  assign ready_fire = (state_q == StWait) && cnt_zero;
  assign resp_done  = (state_q == StResp) &&
                      ((grant_q == GrantWrite) ? bready : rready);

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q      <= StIdle;
      grant_q      <= GrantRead;
      last_grant_q <= GrantRead;
      addr_q       <= '0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
      prot_q       <= '0;
      rdata_q      <= '0;
      err_q        <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            grant_q <= grant_d;
            state_q <= StWait;
          end
        end
        StWait: begin
          if (cnt_zero) begin
            if (grant_q == GrantWrite) begin
              addr_q  <= awaddr;
              wdata_q <= wdata;
              wstrb_q <= wstrb;
              prot_q  <= awprot;
            end else begin
              addr_q  <= araddr;
              wstrb_q <= '0;
              prot_q  <= arprot;
            end
            state_q <= StAccess;
          end
        end
        StAccess: begin
          rdata_q <= mem_rdata;
          err_q   <= mem_err;
          state_q <= StResp;
        end
        StResp: begin
          if (resp_done) begin
            last_grant_q <= grant_q;
            state_q      <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign awready   = ready_fire && (grant_q == GrantWrite);
  assign wready    = ready_fire && (grant_q == GrantWrite);
  assign arready   = ready_fire && (grant_q == GrantRead);

  assign mem_req   = (state_q == StAccess);
  assign mem_we    = mem_req && (grant_q == GrantWrite);
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_wstrb = wstrb_q;
  assign mem_prot  = prot_q;

  assign bvalid    = (state_q == StResp) && (grant_q == GrantWrite);
  assign rvalid    = (state_q == StResp) && (grant_q == GrantRead);
  assign bresp_val = bvalid ? bresp_from_err(err_q) : BrespOkay;
  assign rresp_val = rvalid ? rresp_from_err(err_q) : RrespOkay;
  assign bresp     = bresp_val;
  assign rresp     = rresp_val;
  assign rdata     = rvalid ? rdata_q : '0;

endmodule

// File: tb/tb_axi4_lite_slave_access_scheduler.sv
// Scoreboard bench: stimulus pushes expected accesses and responses, a monitor
// pops and compares them whenever the DUT presents mem_req or a response.
module tb_axi4_lite_slave_access_scheduler;

  logic        aclk = 1'b0;
  logic        areset;
  logic        awvalid, wvalid, arvalid, bready, rready;
  logic [31:0] awaddr, araddr, wdata, mem_rdata;
  logic [2:0]  awprot, arprot;
  logic [3:0]  wstrb;
  logic [4:0]  delay_for_ready;
  logic        mem_err;
  logic        awready, wready, arready, bvalid, rvalid, mem_req, mem_we;
  logic [1:0]  bresp, rresp;
  logic [31:0] rdata, mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [2:0]  mem_prot;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic        is_write;
    logic [1:0]  resp;
    logic [31:0] rdata;
  } exp_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [2:0]  prot;
  } acc_t;

  exp_t exp_q[$];
  acc_t acc_q[$];

  axi4_lite_slave_access_scheduler dut (
    .aclk           (aclk),
    .areset         (areset),
    .awvalid        (awvalid),
    .awaddr         (awaddr),
    .awprot         (awprot),
    .awready        (awready),
    .wvalid         (wvalid),
    .wdata          (wdata),
    .wstrb          (wstrb),
    .wready         (wready),
    .bvalid         (bvalid),
    .bresp          (bresp),
    .bready         (bready),
    .arvalid        (arvalid),
    .araddr         (araddr),
    .arprot         (arprot),
    .arready        (arready),
    .rvalid         (rvalid),
    .rdata          (rdata),
    .rresp          (rresp),
    .rready         (rready),
    .delay_for_ready(delay_for_ready),
    .mem_req        (mem_req),
    .mem_we         (mem_we),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .mem_wstrb      (mem_wstrb),
    .mem_prot       (mem_prot),
    .mem_rdata      (mem_rdata),
    .mem_err        (mem_err)
  );

  always #5 aclk = ~aclk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: per-cycle invariants plus scoreboard pops on mem_req / response handshake.
  always @(negedge aclk) begin
    if (!areset) begin
      chk("readies_exclusive", {63'd0, arready & (awready | wready)}, 64'd0);
      if (!rvalid) chk("rdata_zero_when_idle", {32'd0, rdata}, 64'd0);
      if (mem_req) begin
        if (acc_q.size() == 0) begin
          chk("unexpected_mem_req", 64'd1, 64'd0);
        end else begin
          acc_t a;
          a = acc_q.pop_front();
          chk("mem_we", {63'd0, mem_we}, {63'd0, a.we});
          chk("mem_addr", {32'd0, mem_addr}, {32'd0, a.addr});
          chk("mem_prot", {61'd0, mem_prot}, {61'd0, a.prot});
          if (a.we) begin
            chk("mem_wdata", {32'd0, mem_wdata}, {32'd0, a.wdata});
            chk("mem_wstrb", {60'd0, mem_wstrb}, {60'd0, a.wstrb});
          end
        end
      end
      if ((bvalid && bready) || (rvalid && rready)) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_response", 64'd1, 64'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("resp_channel_is_write", {63'd0, bvalid}, {63'd0, e.is_write});
          if (e.is_write) begin
            chk("bresp", {62'd0, bresp}, {62'd0, e.resp});
          end else begin
            chk("rresp", {62'd0, rresp}, {62'd0, e.resp});
            chk("rdata", {32'd0, rdata}, {32'd0, e.rdata});
          end
        end
      end
    end
  end

  task automatic run_txn(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                         input logic [3:0] strb, input logic [2:0] prot, input logic [4:0] d,
                         input logic [31:0] rdat, input bit err, input int hold);
    exp_t e;
    acc_t a;
    int   cyc;
    int   exp_lat;
    exp_lat         = (d > 5'd15) ? 16 : int'(d) + 1;
    mem_rdata       = rdat;
    mem_err         = err;
    delay_for_ready = d;
    bready          = (hold == 0);
    rready          = (hold == 0);
    e.is_write = wr;
    e.resp     = err ? 2'b10 : 2'b00;
    e.rdata    = wr ? 32'd0 : rdat;
    exp_q.push_back(e);
    a.we    = wr;
    a.addr  = addr;
    a.wdata = data;
    a.wstrb = strb;
    a.prot  = prot;
    acc_q.push_back(a);
    if (wr) begin
      awvalid = 1'b1; awaddr = addr; awprot = prot;
      wvalid  = 1'b1; wdata  = data; wstrb  = strb;
    end else begin
      arvalid = 1'b1; araddr = addr; arprot = prot;
    end
    cyc = 0;
    @(negedge aclk);
    while (!(wr ? (awready && wready) : arready) && cyc < 40) begin
      cyc++;
      // Past the grant edge: a new delay value must not affect this transaction.
      if (cyc == 2) delay_for_ready = 5'd0;
      @(negedge aclk);
    end
    chk(wr ? "write_ready_latency" : "read_ready_latency", 64'(cyc), 64'(exp_lat));
    chk("other_ready_low", {63'd0, wr ? arready : (awready | wready)}, 64'd0);
    @(posedge aclk);
    #1;
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    @(negedge aclk);
    chk("mem_req_after_ready", {63'd0, mem_req}, 64'd1);
    @(negedge aclk);
    chk("resp_valid_after_access", {63'd0, wr ? bvalid : rvalid}, 64'd1);
    for (int i = 0; i < hold; i++) begin
      @(negedge aclk);
      chk("resp_valid_held", {63'd0, wr ? bvalid : rvalid}, 64'd1);
      if (!wr) begin
        chk("rdata_held", {32'd0, rdata}, {32'd0, rdat});
        chk("rresp_held", {62'd0, rresp}, {62'd0, e.resp});
      end
    end
    if (hold > 0) begin
      @(posedge aclk);
      #1;
      bready = 1'b1;
      rready = 1'b1;
      @(negedge aclk);
    end
    @(posedge aclk);
    #1;
  endtask

  task automatic wait_ready(input string name, input bit exp_wr);
    int cyc;
    cyc = 0;
    @(negedge aclk);
    while (!(awready || arready) && cyc < 30) begin
      cyc++;
      @(negedge aclk);
    end
    chk({name, "_in_time"}, {63'd0, cyc < 30}, 64'd1);
    chk({name, "_is_write"}, {63'd0, awready}, {63'd0, exp_wr});
    chk({name, "_is_read"}, {63'd0, arready}, {63'd0, !exp_wr});
    @(posedge aclk);
    #1;
    if (exp_wr) begin
      awvalid = 1'b0; wvalid = 1'b0;
    end else begin
      arvalid = 1'b0;
    end
  endtask

  // Simultaneous write and read; first_wr says which the arbiter must pick first.
  task automatic run_tie(input bit first_wr);
    exp_t ew, er;
    acc_t aw, ar;
    int   cyc;
    delay_for_ready = 5'd0;
    mem_rdata = 32'h0BAD_F00D;
    mem_err   = 1'b0;
    bready    = 1'b1;
    rready    = 1'b1;
    ew.is_write = 1'b1; ew.resp = 2'b00; ew.rdata = 32'd0;
    er.is_write = 1'b0; er.resp = 2'b00; er.rdata = 32'h0BAD_F00D;
    aw.we = 1'b1; aw.addr = 32'h40; aw.wdata = 32'hCAFE_0001; aw.wstrb = 4'h3; aw.prot = 3'd2;
    ar.we = 1'b0; ar.addr = 32'h44; ar.wdata = 32'd0; ar.wstrb = 4'h0; ar.prot = 3'd1;
    if (first_wr) begin
      exp_q.push_back(ew); exp_q.push_back(er);
      acc_q.push_back(aw); acc_q.push_back(ar);
    end else begin
      exp_q.push_back(er); exp_q.push_back(ew);
      acc_q.push_back(ar); acc_q.push_back(aw);
    end
    awvalid = 1'b1; awaddr = 32'h40; awprot = 3'd2;
    wvalid  = 1'b1; wdata  = 32'hCAFE_0001; wstrb = 4'h3;
    arvalid = 1'b1; araddr = 32'h44; arprot = 3'd1;
    wait_ready("tie_first", first_wr);
    wait_ready("tie_second", !first_wr);
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 30) begin
      @(posedge aclk);
      cyc++;
    end
    chk("tie_responses_drained", 64'(exp_q.size()), 64'd0);
    @(posedge aclk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  cyc;
    logic seen;
    areset = 1'b1;
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0; bready = 1'b1; rready = 1'b1;
    awaddr = '0; araddr = '0; wdata = '0; wstrb = '0; awprot = '0; arprot = '0;
    delay_for_ready = '0; mem_rdata = '0; mem_err = 1'b0;
    repeat (3) @(posedge aclk);
    #1;
    chk("reset_outputs", {51'd0, awready, wready, arready, bvalid, bresp, rvalid, rresp,
                          mem_req, mem_we}, 64'd0);
    chk("reset_mem_fields", {mem_addr, mem_wdata}, 64'd0);
    areset = 1'b0;

    // Write, no delay, OKAY.
    run_txn(1'b1, 32'h10, 32'h1234_5678, 4'hF, 3'd0, 5'd0, 32'h0, 1'b0, 0);
    // Read, delay 3, SLVERR, response back-pressured.
    run_txn(1'b0, 32'h20, 32'h0, 4'h0, 3'd4, 5'd3, 32'hDEAD_BEEF, 1'b1, 4);

    // Address without data must not be accepted.
    awvalid = 1'b1; awaddr = 32'h30;
    seen = 1'b0;
    repeat (6) begin
      @(negedge aclk);
      seen = seen | awready | wready | arready | mem_req;
    end
    chk("aw_without_w_not_granted", {63'd0, seen}, 64'd0);
    @(posedge aclk);
    #1;
    run_txn(1'b1, 32'h30, 32'hA5A5_0F0F, 4'h5, 3'd3, 5'd1, 32'h0, 1'b1, 0);

    // Delay above the clamp.
    run_txn(1'b1, 32'h34, 32'h0000_0001, 4'h1, 3'd7, 5'd31, 32'h0, 1'b0, 0);
    run_txn(1'b0, 32'h38, 32'h0, 4'h0, 3'd5, 5'd15, 32'h5A5A_A5A5, 1'b0, 0);

    // Arbitration: last grant was read, so write wins; then read after a write.
    run_tie(1'b1);
    run_txn(1'b1, 32'h50, 32'h1111_2222, 4'hC, 3'd0, 5'd2, 32'h0, 1'b0, 0);
    run_tie(1'b0);

    // Reset while the access strobe is up.
    begin
      acc_t a;
      a.we = 1'b1; a.addr = 32'h60; a.wdata = 32'h7777_8888; a.wstrb = 4'hF; a.prot = 3'd6;
      acc_q.push_back(a);
    end
    delay_for_ready = 5'd2; mem_err = 1'b0; bready = 1'b1; rready = 1'b1;
    awvalid = 1'b1; awaddr = 32'h60; awprot = 3'd6;
    wvalid  = 1'b1; wdata  = 32'h7777_8888; wstrb = 4'hF;
    cyc = 0;
    @(negedge aclk);
    while (!mem_req && cyc < 30) begin
      if (awready) begin
        @(posedge aclk);
        #1;
        awvalid = 1'b0; wvalid = 1'b0;
      end
      cyc++;
      @(negedge aclk);
    end
    chk("reset_test_reached_access", {63'd0, mem_req}, 64'd1);
    #2;
    areset = 1'b1;
    #1;
    chk("async_reset_outputs", {51'd0, awready, wready, arready, bvalid, bresp, rvalid, rresp,
                                mem_req, mem_we}, 64'd0);
    chk("async_reset_mem_fields", {mem_addr, mem_wdata}, 64'd0);
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    repeat (2) @(posedge aclk);
    #1;
    areset = 1'b0;
    chk("access_consumed_before_reset", 64'(acc_q.size()), 64'd0);
    acc_q.delete();
    exp_q.delete();
    seen = 1'b0;
    repeat (10) begin
      @(negedge aclk);
      seen = seen | bvalid | rvalid | mem_req;
    end
    chk("no_response_after_reset", {63'd0, seen}, 64'd0);
    @(posedge aclk);
    #1;
    run_tie(1'b1);

    repeat (2) @(posedge aclk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
